// File: rtl/reg_file_if.sv
// Decoder/ROB facing bundle of the rename register file: two read queries,
// rename (issue), retire (commit) and the global rdy / rollback controls.
interface reg_file_if #(
    parameter int DATA_W   = 32,
    parameter int ROB_ID_W = 4,
    parameter int IDX_W    = 5
);
    logic                rdy;
    logic                rollback;
    logic                is_call_rs1;
    logic [IDX_W-1:0]    call_rs1;
    logic                is_call_rs2;
    logic [IDX_W-1:0]    call_rs2;
    logic [DATA_W-1:0]   rs1_data;
    logic                rs1_busy;
    logic [ROB_ID_W-1:0] rs1_rob_id;
    logic [DATA_W-1:0]   rs2_data;
    logic                rs2_busy;
    logic [ROB_ID_W-1:0] rs2_rob_id;
    logic                issue_valid;
    logic [IDX_W-1:0]    issue_rd;
    logic [ROB_ID_W-1:0] issue_rob_id;
    logic                commit_valid;
    logic [IDX_W-1:0]    commit_rd;
    logic [ROB_ID_W-1:0] commit_rob_id;
    logic [DATA_W-1:0]   commit_data;

    modport master (
        output rdy, rollback, is_call_rs1, call_rs1, is_call_rs2, call_rs2,
               issue_valid, issue_rd, issue_rob_id,
               commit_valid, commit_rd, commit_rob_id, commit_data,
        input  rs1_data, rs1_busy, rs1_rob_id, rs2_data, rs2_busy, rs2_rob_id
    );

    modport slave (
        input  rdy, rollback, is_call_rs1, call_rs1, is_call_rs2, call_rs2,
               issue_valid, issue_rd, issue_rob_id,
               commit_valid, commit_rd, commit_rob_id, commit_data,
        output rs1_data, rs1_busy, rs1_rob_id, rs2_data, rs2_busy, rs2_rob_id
    );
endinterface

// File: rtl/reg_file.sv
// Architectural register file with per-register rename tags (busy + ROB id),
// combinational dual read with commit bypass, issue/commit/rollback updates.
module reg_file #(
    parameter int REG_NUM  = 32,
    parameter int DATA_W   = 32,
    parameter int ROB_ID_W = 4
) (
    input logic       clk,
    input logic       rst,
    reg_file_if.slave bus
);
    localparam int IDX_W = $clog2(REG_NUM);

    typedef struct packed {
        logic [DATA_W-1:0]   data;
        logic                busy;
        logic [ROB_ID_W-1:0] tag;
    } rd_resp_t;

    logic [REG_NUM-1:0][DATA_W-1:0]   data_q, data_d;
    logic [REG_NUM-1:0]               busy_q, busy_d;
    logic [REG_NUM-1:0][ROB_ID_W-1:0] tag_q,  tag_d;
    logic                             issue_hit;
    rd_resp_t                         rs1_r, rs2_r;

    // A commit that retires the exact rename a query would wait on is forwarded
    // so the consumer never sees a stale busy for a value landing this cycle.
    function automatic rd_resp_t rd_port(
        input logic                             call,
        input logic [IDX_W-1:0]                 idx,
        input logic [REG_NUM-1:0][DATA_W-1:0]   d,
        input logic [REG_NUM-1:0]               b,
        input logic [REG_NUM-1:0][ROB_ID_W-1:0] t,
        input logic                             cv,
        input logic [IDX_W-1:0]                 crd,
        input logic [ROB_ID_W-1:0]              ctag,
        input logic [DATA_W-1:0]                cdata
    );
        rd_resp_t r;
        r = '0;
        if (call && idx != '0) begin
            if (cv && crd == idx && b[idx] && t[idx] == ctag) begin
                r.data = cdata;
                r.busy = 1'b0;
                r.tag  = t[idx];
            end else begin
                r.data = d[idx];
                r.busy = b[idx];
                r.tag  = t[idx];
            end
        end
        return r;
    endfunction

    always_comb begin
        rs1_r = rd_port(bus.is_call_rs1, bus.call_rs1, data_q, busy_q, tag_q,
                        bus.commit_valid, bus.commit_rd, bus.commit_rob_id, bus.commit_data);
        rs2_r = rd_port(bus.is_call_rs2, bus.call_rs2, data_q, busy_q, tag_q,
                        bus.commit_valid, bus.commit_rd, bus.commit_rob_id, bus.commit_data);
    end

    assign bus.rs1_data   = rs1_r.data;
    assign bus.rs1_busy   = rs1_r.busy;
    assign bus.rs1_rob_id = rs1_r.tag;
    assign bus.rs2_data   = rs2_r.data;
    assign bus.rs2_busy   = rs2_r.busy;
    assign bus.rs2_rob_id = rs2_r.tag;

    assign issue_hit = bus.rdy && !bus.rollback && bus.issue_valid && bus.issue_rd != '0;

    always_comb begin
        data_d = data_q;
        busy_d = busy_q;
        tag_d  = tag_q;
        if (bus.rdy) begin
            if (bus.commit_valid && bus.commit_rd != '0) begin
                data_d[bus.commit_rd] = bus.commit_data;
                // Tag mismatch means a younger rename still owns the register.
                if (tag_q[bus.commit_rd] == bus.commit_rob_id &&
                    !(issue_hit && bus.issue_rd == bus.commit_rd))
                    busy_d[bus.commit_rd] = 1'b0;
            end
            if (bus.rollback)
                busy_d = '0;
            if (issue_hit) begin
                busy_d[bus.issue_rd] = 1'b1;
                tag_d[bus.issue_rd]  = bus.issue_rob_id;
            end
        end
        data_d[0] = '0;
        busy_d[0] = 1'b0;
        tag_d[0]  = '0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            data_q <= '0;
            busy_q <= '0;
            tag_q  <= '0;
        end else begin
            data_q <= data_d;
            busy_q <= busy_d;
            tag_q  <= tag_d;
        end
    end
endmodule

// File: tb/tb_reg_file.sv
// Directed table-driven bench for reg_file: each vector drives one cycle of
// inputs, checks the combinational read outputs, then lets the edge occur.
module tb_reg_file;
    logic clk = 1'b0;
    logic rst;
    int   checks   = 0;
    int   failures = 0;

    always #5 clk = ~clk;

    reg_file_if #(.DATA_W(32), .ROB_ID_W(4), .IDX_W(5)) bus ();

    reg_file #(.REG_NUM(32), .DATA_W(32), .ROB_ID_W(4)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct {
        logic        rdy, rb;
        logic        c1;  logic [4:0] i1;
        logic        c2;  logic [4:0] i2;
        logic        iv;  logic [4:0] ird; logic [3:0] itag;
        logic        cv;  logic [4:0] crd; logic [3:0] ctag; logic [31:0] cdata;
        logic [31:0] d1;  logic b1; logic [3:0] t1;
        logic [31:0] d2;  logic b2; logic [3:0] t2;
    } vec_t;

    vec_t vecs[25];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", nm, act, exp);
        end
    endtask

    task automatic drive(input vec_t v);
        bus.rdy           = v.rdy;
        bus.rollback      = v.rb;
        bus.is_call_rs1   = v.c1;
        bus.call_rs1      = v.i1;
        bus.is_call_rs2   = v.c2;
        bus.call_rs2      = v.i2;
        bus.issue_valid   = v.iv;
        bus.issue_rd      = v.ird;
        bus.issue_rob_id  = v.itag;
        bus.commit_valid  = v.cv;
        bus.commit_rd     = v.crd;
        bus.commit_rob_id = v.ctag;
        bus.commit_data   = v.cdata;
    endtask

    task automatic check_out(input string tag, input vec_t v);
        chk({tag, " rs1_data"},   bus.rs1_data,   v.d1);
        chk({tag, " rs1_busy"},   32'(bus.rs1_busy),   32'(v.b1));
        chk({tag, " rs1_rob_id"}, 32'(bus.rs1_rob_id), 32'(v.t1));
        chk({tag, " rs2_data"},   bus.rs2_data,   v.d2);
        chk({tag, " rs2_busy"},   32'(bus.rs2_busy),   32'(v.b2));
        chk({tag, " rs2_rob_id"}, 32'(bus.rs2_rob_id), 32'(v.t2));
    endtask

    initial begin
        vec_t idle;
        vec_t h;
        //          rdy rb c1 i1 c2 i2  iv ird itag cv crd ctag cdata           d1           b1 t1  d2           b2 t2
        vecs[0]  = '{1, 0, 1, 5, 1, 0,  0, 0,  0,   0, 0,  0,   32'h0,          32'h0,       0, 0,  32'h0,       0, 0};
        vecs[1]  = '{1, 0, 1, 3, 0, 0,  1, 3,  2,   0, 0,  0,   32'h0,          32'h0,       0, 0,  32'h0,       0, 0};
        vecs[2]  = '{1, 0, 1, 3, 1, 3,  0, 0,  0,   0, 0,  0,   32'h0,          32'h0,       1, 2,  32'h0,       1, 2};
        vecs[3]  = '{1, 0, 1, 3, 0, 3,  0, 0,  0,   1, 3,  2,   32'hDEADBEEF,   32'hDEADBEEF,0, 2,  32'h0,       0, 0};
        vecs[4]  = '{1, 0, 1, 3, 0, 0,  0, 0,  0,   0, 0,  0,   32'h0,          32'hDEADBEEF,0, 2,  32'h0,       0, 0};
        vecs[5]  = '{1, 0, 1, 4, 0, 0,  1, 4,  1,   0, 0,  0,   32'h0,          32'h0,       0, 0,  32'h0,       0, 0};
        vecs[6]  = '{1, 0, 1, 4, 0, 0,  1, 4,  5,   0, 0,  0,   32'h0,          32'h0,       1, 1,  32'h0,       0, 0};
        vecs[7]  = '{1, 0, 1, 4, 0, 0,  0, 0,  0,   1, 4,  1,   32'h7,          32'h0,       1, 5,  32'h0,       0, 0};
        vecs[8]  = '{1, 0, 1, 4, 1, 4,  0, 0,  0,   1, 4,  5,   32'h9,          32'h9,       0, 5,  32'h9,       0, 5};
        vecs[9]  = '{1, 0, 1, 4, 0, 0,  0, 0,  0,   0, 0,  0,   32'h0,          32'h9,       0, 5,  32'h0,       0, 0};
        vecs[10] = '{1, 0, 0, 0, 0, 0,  1, 6,  3,   0, 0,  0,   32'h0,          32'h0,       0, 0,  32'h0,       0, 0};
        vecs[11] = '{1, 0, 1, 6, 0, 0,  1, 6,  7,   1, 6,  3,   32'h11,         32'h11,      0, 3,  32'h0,       0, 0};
        vecs[12] = '{1, 0, 1, 6, 0, 0,  0, 0,  0,   0, 0,  0,   32'h0,          32'h11,      1, 7,  32'h0,       0, 0};
        vecs[13] = '{1, 0, 0, 0, 0, 0,  1, 8,  1,   0, 0,  0,   32'h0,          32'h0,       0, 0,  32'h0,       0, 0};
        vecs[14] = '{1, 0, 1, 8, 0, 0,  1, 9,  2,   0, 0,  0,   32'h0,          32'h0,       1, 1,  32'h0,       0, 0};
        vecs[15] = '{1, 1, 1, 8, 1, 9,  1, 10, 3,   1, 9,  2,   32'h77,         32'h0,       1, 1,  32'h77,      0, 2};
        vecs[16] = '{1, 0, 1, 10,1, 9,  0, 0,  0,   0, 0,  0,   32'h0,          32'h0,       0, 0,  32'h77,      0, 2};
        vecs[17] = '{1, 0, 1, 8, 1, 6,  0, 0,  0,   0, 0,  0,   32'h0,          32'h0,       0, 1,  32'h11,      0, 7};
        vecs[18] = '{1, 0, 1, 0, 0, 0,  1, 0,  4,   1, 0,  0,   32'h55,         32'h0,       0, 0,  32'h0,       0, 0};
        vecs[19] = '{1, 0, 1, 0, 1, 0,  0, 0,  0,   0, 0,  0,   32'h0,          32'h0,       0, 0,  32'h0,       0, 0};
        vecs[20] = '{0, 0, 1, 2, 0, 0,  1, 2,  1,   1, 2,  0,   32'h99,         32'h0,       0, 0,  32'h0,       0, 0};
        vecs[21] = '{1, 0, 1, 2, 0, 0,  0, 0,  0,   0, 0,  0,   32'h0,          32'h0,       0, 0,  32'h0,       0, 0};
        vecs[22] = '{1, 0, 0, 0, 0, 0,  1, 2,  1,   0, 0,  0,   32'h0,          32'h0,       0, 0,  32'h0,       0, 0};
        vecs[23] = '{1, 0, 1, 2, 0, 0,  0, 0,  0,   1, 2,  1,   32'h99,         32'h99,      0, 1,  32'h0,       0, 0};
        vecs[24] = '{1, 0, 1, 2, 1, 3,  0, 0,  0,   0, 0,  0,   32'h0,          32'h99,      0, 1,  32'hDEADBEEF,0, 2};

        idle = '{1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 32'h0, 32'h0, 0, 0, 32'h0, 0, 0};

        rst = 1'b1;
        drive(idle);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < 25; i++) begin
            drive(vecs[i]);
            #1;
            check_out($sformatf("v%0d", i), vecs[i]);
            @(posedge clk);
            @(negedge clk);
        end

        // Reset asserted together with an issue and a commit: both are dropped
        // and every register, including previously written ones, reads clean.
        h = idle;
        h.iv = 1; h.ird = 12; h.itag = 6;
        h.cv = 1; h.crd = 5;  h.ctag = 0; h.cdata = 32'hAB;
        drive(h);
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        h = '{1, 0, 1, 3, 1, 12, 0, 0, 0, 0, 0, 0, 32'h0, 32'h0, 0, 0, 32'h0, 0, 0};
        drive(h);
        #1;
        check_out("rst_mid_a", h);
        h = '{1, 0, 1, 5, 1, 4, 0, 0, 0, 0, 0, 0, 32'h0, 32'h0, 0, 0, 32'h0, 0, 0};
        drive(h);
        #1;
        check_out("rst_mid_b", h);
        @(posedge clk);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
